// File: rtl/video_pattern_gen_pkg.sv
// Shared types and constants for the video pattern generator: FSM states,
// pattern modes, colour-bar palette and the 6:2 counter packing helper.
package video_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } vpg_state_e;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_RSVD    = 2'd3
  } vpg_mode_e;

  localparam logic [PIX_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [PIX_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [PIX_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [PIX_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [PIX_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [PIX_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [PIX_W-1:0] BAR_BLACK   = 24'h000000;

  // Spread an 18-bit counter over the top 6 bits of each colour channel.
  function automatic logic [PIX_W-1:0] pack_counter(input logic [CNT_W-1:0] d);
    return {d[17:12], 2'b00, d[11:6], 2'b00, d[5:0], 2'b00};
  endfunction

endpackage

// File: rtl/vpg_bar_lut.sv
// Colour-bar palette lookup: 3-bit bar index to 24-bit RGB.
module vpg_bar_lut
  import video_pkg::*;
(
  input  logic [2:0]       bar_idx_i,
  output logic [PIX_W-1:0] rgb_c_o
);

  always_comb begin
    rgb_c_o = BAR_BLACK;
    case (bar_idx_i)
      3'd0:    rgb_c_o = BAR_WHITE;
      3'd1:    rgb_c_o = BAR_YELLOW;
      3'd2:    rgb_c_o = BAR_CYAN;
      3'd3:    rgb_c_o = BAR_GREEN;
      3'd4:    rgb_c_o = BAR_MAGENTA;
      3'd5:    rgb_c_o = BAR_RED;
      3'd6:    rgb_c_o = BAR_BLUE;
      default: rgb_c_o = BAR_BLACK;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source for an AXI4-Stream video sink: counter, colour bars or
// solid fill, with per-line and per-frame blanking and a completed-frame count.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 1750,
  parameter int unsigned V_BLANK  = 500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] solid_rgb,
  output logic [PIX_W-1:0] m_axis_video_tdata,
  output logic             m_axis_video_tvalid,
  input  logic             m_axis_video_tready,
  output logic             m_axis_video_tuser,
  output logic             m_axis_video_tlast,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [31:0]   HB_LAST  = 32'(H_BLANK - 1);
  localparam logic [31:0]   VB_LAST  = 32'(V_BLANK - 1);

  vpg_state_e       state_q, state_d;
  vpg_mode_e        mode_q, mode_d;
  logic [PIX_W-1:0] solid_q, solid_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BW-1:0]    bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [31:0]      blank_q, blank_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             busy_q, busy_d;
  logic             tvalid_q, tvalid_d;
  logic             tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic [PIX_W-1:0] tdata_q, tdata_d;

  logic             accept_c;
  logic             load_beat_c;
  logic             end_line_c;
  logic [PIX_W-1:0] bar_rgb_c;
  logic [PIX_W-1:0] pix_c;

  assign accept_c = tvalid_q & m_axis_video_tready;

  // Sequencing: state, raster position, bar sub-counter, blank timer, counters.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    blank_d     = blank_q;
    d_d         = d_q;
    frame_cnt_d = frame_cnt_q;
    load_beat_c = 1'b0;
    end_line_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_ACTIVE;
          mode_d      = vpg_mode_e'(mode);
          solid_d     = solid_rgb;
          load_beat_c = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (accept_c) begin
          d_d = d_q + CNT_W'(1);
          if (x_q == X_LAST) begin
            end_line_c = 1'b1;
            x_d        = '0;
            bar_cnt_d  = '0;
            bar_idx_d  = '0;
            blank_d    = '0;
            if (y_q < Y_LAST) begin
              y_d     = y_q + YW'(1);
              state_d = ST_HBLANK;
            end else begin
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = ST_VBLANK;
            end
          end else begin
            x_d         = x_q + XW'(1);
            load_beat_c = 1'b1;
            if (bar_cnt_q == BAR_LAST) begin
              bar_cnt_d = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_cnt_d = bar_cnt_q + BW'(1);
            end
          end
        end
      end
      ST_HBLANK: begin
        if (blank_q == HB_LAST) begin
          state_d     = ST_ACTIVE;
          load_beat_c = 1'b1;
        end else begin
          blank_d = blank_q + 32'd1;
        end
      end
      ST_VBLANK: begin
        if (blank_q == VB_LAST) begin
          if (enable) begin
            state_d     = ST_ACTIVE;
            mode_d      = vpg_mode_e'(mode);
            solid_d     = solid_rgb;
            load_beat_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          blank_d = blank_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vpg_bar_lut u_bar_lut (
    .bar_idx_i (bar_idx_d),
    .rgb_c_o   (bar_rgb_c)
  );

  // Next beat is built from the post-update position so it is ready the
  // cycle the previous one is accepted; otherwise the output regs hold.
  always_comb begin
    pix_c    = pack_counter(d_d);
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;

    case (mode_d)
      MODE_BARS:  pix_c = bar_rgb_c;
      MODE_SOLID: pix_c = solid_d;
      default:    pix_c = pack_counter(d_d);
    endcase

    if (load_beat_c) begin
      tvalid_d = 1'b1;
      tdata_d  = pix_c;
      tuser_d  = (x_d == '0) && (y_d == '0);
      tlast_d  = (x_d == X_LAST);
    end else if (end_line_c) begin
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COUNTER;
      solid_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      blank_q     <= '0;
      d_q         <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      blank_q     <= blank_d;
      d_q         <= d_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
    end
  end

  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign frame_cnt           = frame_cnt_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with a frame-level reference model
// checked on every cycle a beat is presented.
module tb_video_pattern_gen;

  localparam int unsigned HA = 16;
  localparam int unsigned VA = 4;
  localparam int unsigned HB = 3;
  localparam int unsigned VB = 10;
  localparam int unsigned NB = HA * VA;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [15:0] frame_cnt;
  logic        busy;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_BLANK  (VB)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .enable              (enable),
    .mode                (mode),
    .solid_rgb           (solid_rgb),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .frame_cnt           (frame_cnt),
    .busy                (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Expected pixel from the pattern rules, using plain arithmetic.
  function automatic logic [23:0] model_pix(input logic [1:0] m, input logic [23:0] s,
                                            input int unsigned x, input int unsigned d);
    int unsigned r, g, b;
    case (m)
      2'd1: return bars[x / (HA / 8)];
      2'd2: return s;
      default: begin
        r = ((d >> 12) % 64) * 4;
        g = ((d >> 6) % 64) * 4;
        b = (d % 64) * 4;
        return 24'((r << 16) | (g << 8) | b);
      end
    endcase
  endfunction

  // Reference model state
  bit          mon_on    = 1'b0;
  int unsigned n         = 0;
  int unsigned md        = 0;
  int unsigned mfc       = 0;
  logic [1:0]  fm        = 2'd0;
  logic [23:0] fs        = 24'd0;
  bit          hold_pend = 1'b0;
  logic [23:0] h_data    = 24'd0;
  logic        h_user    = 1'b0;
  logic        h_last    = 1'b0;
  int          hold_seen = 0;
  bit          gap_arm   = 1'b0;
  int unsigned gap       = 0;
  logic [23:0] cap      [NB];
  logic        cap_user [NB];
  logic        cap_last [NB];

  always @(negedge clk) begin
    if (mon_on) begin
      check("frame_cnt", 32'(frame_cnt), 32'(mfc));
      if (tvalid) begin
        check("busy_in_beat", 32'(busy), 32'd1);
        if (hold_pend) begin
          check("hold_tdata", 32'(tdata), 32'(h_data));
          check("hold_tuser", 32'(tuser), 32'(h_user));
          check("hold_tlast", 32'(tlast), 32'(h_last));
        end else begin
          if (n == 0) begin
            fm = mode;
            fs = solid_rgb;
          end
          if (gap_arm) begin
            check("blank_len", gap, (n == 0) ? VB : HB);
            gap_arm = 1'b0;
          end
        end
        check("tdata", 32'(tdata), 32'(model_pix(fm, fs, n % HA, md)));
        check("tuser", 32'(tuser), 32'(n == 0));
        check("tlast", 32'(tlast), 32'((n % HA) == HA - 1));
        if (tready) begin
          cap[n]      = tdata;
          cap_user[n] = tuser;
          cap_last[n] = tlast;
          hold_pend   = 1'b0;
          n++;
          md = (md + 1) % 262144;
          if ((n % HA) == 0) begin
            gap_arm = 1'b1;
            gap     = 0;
          end
          if (n == NB) begin
            n   = 0;
            mfc = (mfc + 1) % 65536;
          end
        end else begin
          hold_pend = 1'b1;
          hold_seen++;
          h_data = tdata;
          h_user = tuser;
          h_last = tlast;
        end
      end else begin
        if (hold_pend) begin
          check("hold_valid", 32'(tvalid), 32'd1);
          hold_pend = 1'b0;
        end
        gap++;
        if (!busy) gap_arm = 1'b0;
      end
      if (!rstn) begin
        n         = 0;
        md        = 0;
        mfc       = 0;
        hold_pend = 1'b0;
        gap_arm   = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fc(input int unsigned tgt, input bit tog);
    for (int i = 0; i < 4000; i++) begin
      if (32'(frame_cnt) == tgt) break;
      tick();
      tready = tog ? ~tready : 1'b1;
    end
    check("wait_frame_cnt", 32'(frame_cnt), tgt);
  endtask

  task automatic wait_n(input int unsigned k);
    for (int i = 0; i < 4000; i++) begin
      if (n >= k) break;
      tick();
    end
    check("wait_beats", 32'(n >= k), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  int vb_len;
  int stray;

  initial begin
    rstn      = 1'b0;
    enable    = 1'b0;
    mode      = 2'd0;
    solid_rgb = 24'd0;
    tready    = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    rstn   = 1'b1;
    mon_on = 1'b1;
    repeat (5) tick();
    check("idle_no_beat", 32'(tvalid), 32'd0);

    // Frame 1: counter, full rate
    enable = 1'b1;
    tick();
    check("first_beat_valid", 32'(tvalid), 32'd1);
    check("first_beat_tuser", 32'(tuser), 32'd1);
    wait_fc(1, 1'b0);
    check("f1_beat0", 32'(cap[0]), 32'h000000);
    check("f1_beat1", 32'(cap[1]), 32'h000004);
    check("f1_beat63", 32'(cap[63]), 32'h0000FC);
    check("f1_tuser0", 32'(cap_user[0]), 32'd1);
    check("f1_tuser1", 32'(cap_user[1]), 32'd0);
    check("f1_tlast14", 32'(cap_last[14]), 32'd0);
    check("f1_tlast15", 32'(cap_last[15]), 32'd1);
    check("f1_tlast31", 32'(cap_last[31]), 32'd1);
    check("f1_tlast47", 32'(cap_last[47]), 32'd1);
    check("f1_tlast63", 32'(cap_last[63]), 32'd1);

    // Frame 2: colour bars, back to back
    mode = 2'd1;
    wait_fc(2, 1'b0);
    check("bar_px0", 32'(cap[0]), 32'hFFFFFF);
    check("bar_px1", 32'(cap[1]), 32'hFFFFFF);
    check("bar_px2", 32'(cap[2]), 32'hFFFF00);
    check("bar_px5", 32'(cap[5]), 32'h00FFFF);
    check("bar_l1_px6", 32'(cap[22]), 32'h00FF00);
    check("bar_l2_px9", 32'(cap[41]), 32'hFF00FF);
    check("bar_l3_px15", 32'(cap[63]), 32'h000000);

    // Frame 3: counter with tready toggling
    mode = 2'd0;
    wait_fc(3, 1'b1);
    tready = 1'b1;
    enable = 1'b0;
    wait_idle();
    check("f3_beat0", 32'(cap[0]), 32'h000800);
    check("f3_beat1", 32'(cap[1]), 32'h000804);
    check("hold_seen", 32'(hold_seen > 0), 32'd1);

    // Frame 4: solid, mode switched mid-frame
    mode      = 2'd2;
    solid_rgb = 24'h123456;
    enable    = 1'b1;
    wait_n(20);
    mode = 2'd0;
    wait_fc(4, 1'b0);
    check("solid_px0", 32'(cap[0]), 32'h123456);
    check("solid_px20", 32'(cap[20]), 32'h123456);
    check("solid_px63", 32'(cap[63]), 32'h123456);

    // Frame 5: counter again, enable dropped during line 1
    wait_n(20);
    enable = 1'b0;
    wait_fc(5, 1'b0);
    check("f5_beat0", 32'(cap[0]), 32'h001000);
    vb_len = 0;
    while (busy && vb_len < 100) begin
      tick();
      vb_len++;
    end
    check("vblank_to_idle", 32'(vb_len), VB);
    stray = 0;
    repeat (30) begin
      tick();
      if (tvalid || busy) stray++;
    end
    check("idle_after_frame", 32'(stray), 32'd0);

    // Frame 6: reset mid-beat with tready low
    enable = 1'b1;
    wait_n(20);
    tready = 1'b0;
    tick();
    tick();
    rstn   = 1'b0;
    enable = 1'b0;
    tick();
    rstn = 1'b1;
    check("rst2_tvalid", 32'(tvalid), 32'd0);
    check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_tdata", 32'(tdata), 32'd0);
    check("rst2_tuser", 32'(tuser), 32'd0);
    repeat (3) tick();
    check("rst2_no_beat", 32'(tvalid), 32'd0);
    tready = 1'b1;
    enable = 1'b1;
    tick();
    check("restart_valid", 32'(tvalid), 32'd1);
    check("restart_tuser", 32'(tuser), 32'd1);
    check("restart_tdata", 32'(tdata), 32'd0);
    wait_fc(1, 1'b0);
    enable = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per line; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter V_ACTIVE, default 480, lines per frame; SHALL be at least 1.
REQ-003 Parameter H_BLANK, default 1750, idle clk cycles after each non-final line; SHALL be at least 1.
REQ-004 Parameter V_BLANK, default 500000, idle clk cycles after the final line of a frame; SHALL be at least 1 and fit in 32 bits.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 enable  input  1  level; start or continue frame generation.
REQ-008 mode  input  2  pattern select: 0 counter, 1 colour bars, 2 solid, 3 treated as 0.
REQ-009 solid_rgb  input  24  pixel value for mode 2.
REQ-010 m_axis_video_tdata  output  24  pixel, {R[7:0],G[7:0],B[7:0]}.
REQ-011 m_axis_video_tvalid  output  1  beat valid.
REQ-012 m_axis_video_tready  input  1  downstream (MyYCbCr) ready.
REQ-013 m_axis_video_tuser  output  1  start of frame; high on first pixel of line 0 only.
REQ-014 m_axis_video_tlast  output  1  end of line; high on pixel H_ACTIVE-1 of every line.
REQ-015 frame_cnt  output  16  completed frames, wraps 0xFFFF->0.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
REQ-018 IDLE->ACTIVE on the cycle after enable is sampled high; mode and solid_rgb are latched at this transition and at VBLANK->ACTIVE, and held for the whole frame.
REQ-019 ACTIVE: tvalid high; x counts accepted beats (tvalid&&tready) 0..H_ACTIVE-1, y counts lines 0..V_ACTIVE-1.
REQ-020 Acceptance of x=H_ACTIVE-1: if y<V_ACTIVE-1 go HBLANK, y+1; else go VBLANK, y=0, frame_cnt+1.
REQ-021 HBLANK: tvalid low for exactly H_BLANK cycles, then ACTIVE.
REQ-022 VBLANK: tvalid low for exactly V_BLANK cycles, then ACTIVE if enable high on last VBLANK cycle, else IDLE.
REQ-023 Blank counters count every clk cycle independent of tready.
REQ-024 AXI hold rule: while tvalid&&!tready, tdata, tuser, tlast SHALL stay stable; tvalid SHALL not drop until the beat is accepted.
REQ-025 enable deassertion mid-frame SHALL not truncate the frame; the frame and its VBLANK complete first.
REQ-026 Mode 0: 18-bit counter d, output {d[17:12],2'b00,d[11:6],2'b00,d[5:0],2'b00}; d increments on every accepted beat, wraps 0x3FFFF->0, reset only by rstn.
REQ-027 Mode 1: eight bars of H_ACTIVE/8 pixels, order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000; bar index from a sub-counter, no divider.
REQ-028 Mode 2: every pixel = latched solid_rgb.
REQ-029 tuser and tlast on the same beat SHALL occur only when H_ACTIVE=1 (excluded by REQ-001).
REQ-030 Outputs are registered; first beat of a frame appears one cycle after entering ACTIVE at the latest.

Reset
REQ-031 rstn low at a clk edge SHALL force IDLE, x=y=0, d=0, frame_cnt=0, tvalid=tuser=tlast=0, tdata=0, busy=0, regardless of state, including mid-beat with tready low.
REQ-032 After rstn release, no beat SHALL be issued until enable is sampled high.

Structure
REQ-033 Shared package video_pkg holds the FSM state enum, mode encodings, bar colour constants and the 6:2 packing function.
REQ-034 One sub-module, vpg_bar_lut, maps 3-bit bar index to 24-bit colour; all else in the top.

Verification (H_ACTIVE=16, V_ACTIVE=4, H_BLANK=3, V_BLANK=10)
REQ-035 Enable=1, mode 0, tready=1 -> 64 beats, tuser on beat 0 data 0x000000, beat 1 data 0x000004, tlast on beats 15/31/47/63, 3 idle cycles between lines, frame_cnt=1 after beat 63.
REQ-036 Mode 1, tready=1 -> pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000 on every line.
REQ-037 Mode 0, tready toggling 1010... -> each beat held while tready low, 64 accepted beats, d sequence 0..63 without gaps or repeats.
REQ-038 Mode 2 solid_rgb=123456, switch mode to 0 mid-frame -> frame stays 123456; next frame uses counter.
REQ-039 Enable dropped at line 1 -> frame completes (64 beats), 10 VBLANK cycles, IDLE, busy=0, no further beats.
REQ-040 rstn low for one cycle at beat 20 with tready low -> next cycle tvalid=0, frame_cnt=0; re-enable restarts with tuser and data 0x000000.
